// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Shared types and constants for the board LED pattern generator.
//   led_mode_e  : run-time pattern select (ROTL, ROTR, BOUNCE, FILL)
//   led_dir_e   : travel direction of the BOUNCE one-hot
//   SYNC_DEPTH  : flop count of the reset and switch synchronisers
//   seed()      : bit index lit by a mode's seed pattern (-1 means all dark)
// ----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        ROTL   = 2'd0,
        ROTR   = 2'd1,
        BOUNCE = 2'd2,
        FILL   = 2'd3
    } led_mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } led_dir_e;

    localparam int SYNC_DEPTH = 2;

    // Every seed is either a single lit LED or all dark, so the seed is
    // described by the index of the lit LED. Returning an index keeps the
    // function independent of the LED array width.
    function automatic int seed(input led_mode_e mode, input int led_w);
        case (mode)
            ROTR:    return led_w - 1;
            FILL:    return -1;
            default: return 0;      // ROTL and BOUNCE start at bit 0
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_gen_rst_sync.sv
// ----------------------------------------------------------------------------
// rst_sync
// Asynchronous-assert / synchronous-deassert reset synchroniser.
// rst_n drops as soon as arst_n drops and rises on the DEPTH-th clock edge
// after arst_n rises. Reusable by any block under the top level.
// Ports:
//   clk     in  1  destination clock
//   arst_n  in  1  raw asynchronous active-low reset
//   rst_n   out 1  synchronised active-low reset
// ----------------------------------------------------------------------------
module rst_sync
    import led_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic clk,
    input  logic arst_n,
    output logic rst_n
);

    logic [DEPTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[DEPTH-2:0], 1'b1};
        end
    end

    assign rst_n = sync_reg[DEPTH-1];

endmodule

// File: rtl/led_pattern_gen.sv
// ----------------------------------------------------------------------------
// led_pattern_gen
// Board LED pattern generator. A free-running prescaler produces one step
// tick every 2^CNT_W clocks; on each unpaused tick the LED pattern either
// loads the seed of a newly selected mode or advances one step.
// Optional feature macro: LED_PWM_EN (global brightness PWM, registered
// LED output, adds brightness_i port).
// Ports:
//   OSC_50m       in  1      50 MHz clock
//   FPGA_RSTn     in  1      asynchronous active-low reset
//   mode_i        in  2      pattern select (async): ROTL/ROTR/BOUNCE/FILL
//   pause_i       in  1      freeze pattern (async), active-high
//   brightness_i  in  PWM_W  PWM duty (LED_PWM_EN only)
//   USER_LED      out LED_W  LED drive, active-high
//   step_o        out 1      one-cycle pulse on the first cycle of a new pattern
// ----------------------------------------------------------------------------
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CNT_W = 25,
    parameter int LED_W = 10,
    parameter int PWM_W = 8
) (
    input  logic             OSC_50m,
    input  logic             FPGA_RSTn,
    input  logic [1:0]       mode_i,
    input  logic             pause_i,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0] brightness_i,
`endif
    output logic [LED_W-1:0] USER_LED,
    output logic             step_o
);

    logic rst_n;

    rst_sync #(
        .DEPTH (SYNC_DEPTH)
    ) u_rst_sync (
        .clk    (OSC_50m),
        .arst_n (FPGA_RSTn),
        .rst_n  (rst_n)
    );

    // ------------------------------------------------------------------
    // Switch synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_DEPTH-1:0][1:0] mode_sync_reg;
    logic [SYNC_DEPTH-1:0]      pause_sync_reg;
    led_mode_e                  mode_s;
    logic                       pause_s;

    always_ff @(posedge OSC_50m or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync_reg  <= '0;
            pause_sync_reg <= '0;
        end else begin
            mode_sync_reg  <= {mode_sync_reg[SYNC_DEPTH-2:0], mode_i};
            pause_sync_reg <= {pause_sync_reg[SYNC_DEPTH-2:0], pause_i};
        end
    end

    assign mode_s  = led_mode_e'(mode_sync_reg[SYNC_DEPTH-1]);
    assign pause_s = pause_sync_reg[SYNC_DEPTH-1];

    // ------------------------------------------------------------------
    // Prescaler: never paused, so pausing does not shift the tick phase
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg;
    logic             tick;
    logic             adv;

    always_ff @(posedge OSC_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = &cnt_reg;
    assign adv  = tick & ~pause_s;

    // ------------------------------------------------------------------
    // Seed pattern for the currently selected mode
    // ------------------------------------------------------------------
    int               seed_idx;
    logic [LED_W-1:0] seed_vec;

    assign seed_idx = seed(mode_s, LED_W);

    generate
        for (genvar gi = 0; gi < LED_W; gi++) begin : g_seed
            assign seed_vec[gi] = (seed_idx == gi);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pattern state machine
    // ------------------------------------------------------------------
    logic [LED_W-1:0] pattern_reg;
    led_mode_e        mode_reg;
    led_dir_e         dir_reg;
    logic             step_reg;

    always_ff @(posedge OSC_50m or negedge rst_n) begin
        if (!rst_n) begin
            pattern_reg <= LED_W'(1);
            mode_reg    <= ROTL;
            dir_reg     <= DIR_LEFT;
            step_reg    <= 1'b0;
        end else begin
            step_reg <= adv;
            if (adv) begin
                if (mode_s != mode_reg) begin
                    mode_reg    <= mode_s;
                    pattern_reg <= seed_vec;
                    dir_reg     <= DIR_LEFT;
                end else begin
                    case (mode_reg)
                        ROTL: pattern_reg <= {pattern_reg[LED_W-2:0], pattern_reg[LED_W-1]};
                        ROTR: pattern_reg <= {pattern_reg[0], pattern_reg[LED_W-1:1]};
                        BOUNCE: begin
                            // Direction flips on the step that arrives at an
                            // end, so each end bit is shown for one step only.
                            if (dir_reg == DIR_LEFT) begin
                                pattern_reg <= pattern_reg << 1;
                                if (pattern_reg[LED_W-2]) begin
                                    dir_reg <= DIR_RIGHT;
                                end
                            end else begin
                                pattern_reg <= pattern_reg >> 1;
                                if (pattern_reg[1]) begin
                                    dir_reg <= DIR_LEFT;
                                end
                            end
                        end
                        FILL: begin
                            if (&pattern_reg) begin
                                pattern_reg <= '0;
                            end else begin
                                pattern_reg <= {pattern_reg[LED_W-2:0], 1'b1};
                            end
                        end
                        default: pattern_reg <= pattern_reg;
                    endcase
                end
            end
        end
    end

    assign step_o = step_reg;

    // ------------------------------------------------------------------
    // LED output stage
    // ------------------------------------------------------------------
`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_reg;
    logic [LED_W-1:0] led_reg;

    // Strict compare: brightness 0 is always dark, full scale leaves one
    // dark slot per PWM period.
    always_ff @(posedge OSC_50m or negedge rst_n) begin
        if (!rst_n) begin
            pwm_reg <= '0;
            led_reg <= '0;
        end else begin
            pwm_reg <= pwm_reg + 1'b1;
            led_reg <= pattern_reg & {LED_W{pwm_reg < brightness_i}};
        end
    end

    assign USER_LED = led_reg;
`else
    assign USER_LED = pattern_reg;
`endif

endmodule
